// File: rtl/iter_div.sv
// rtl/iter_div.sv - 32-bit iterative restoring divider, signed/unsigned, result {rem, quo}
// Macro ITER_DIV_ZERO_FAST_EN: a zero divisor short-circuits through DZ and yields 64'h0.
module iter_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        annul_i,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

`ifdef ITER_DIV_ZERO_FAST_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, DZ = 2'd2, END = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, END = 2'd3} state_t;
`endif

    state_t      state, stateNext;
    logic [5:0]  cnt;
    logic [64:0] partial;
    logic [31:0] divisor;
    logic        signedOp, signA, signB;

    logic        load, step, finish, dzDone, clear;
    logic [31:0] absA, absB;
    logic [33:0] diff;
    logic [64:0] stepVal;
    logic [31:0] quot, rem;

    assign absA = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    assign absB = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

    // Shifted remainder window is partial[64:31]; a non-negative difference sets the quotient bit.
    assign diff    = partial[64:31] - {2'b00, divisor};
    assign stepVal = diff[33] ? {partial[63:0], 1'b0} : {diff[32:0], partial[30:0], 1'b1};

    assign quot = (signedOp && (signA ^ signB)) ? (~partial[31:0] + 32'd1) : partial[31:0];
    assign rem  = (signedOp && signA) ? (~partial[63:32] + 32'd1) : partial[63:32];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        dzDone    = 1'b0;
        clear     = 1'b0;
        case (state)
            IDLE: begin
                if (start_i && !annul_i) begin
                    load      = 1'b1;
                    stateNext = ON;
`ifdef ITER_DIV_ZERO_FAST_EN
                    if (opdata2_i == 32'd0) begin
                        stateNext = DZ;
                    end
`endif
                end
            end
            ON: begin
                if (annul_i) begin
                    clear     = 1'b1;
                    stateNext = IDLE;
                end else if (cnt == 6'd32) begin
                    finish    = 1'b1;
                    stateNext = END;
                end else begin
                    step = 1'b1;
                end
            end
`ifdef ITER_DIV_ZERO_FAST_EN
            DZ: begin
                // One dwell cycle so ready rises after the second edge.
                if (annul_i) begin
                    clear     = 1'b1;
                    stateNext = IDLE;
                end else if (cnt == 6'd1) begin
                    dzDone    = 1'b1;
                    stateNext = END;
                end else begin
                    step = 1'b1;
                end
            end
`endif
            END: begin
                if (!start_i || annul_i) begin
                    clear     = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: begin
                clear     = 1'b1;
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= 6'd0;
            partial  <= 65'd0;
            divisor  <= 32'd0;
            signedOp <= 1'b0;
            signA    <= 1'b0;
            signB    <= 1'b0;
            result_o <= 64'h0;
            ready_o  <= 1'b0;
        end else begin
            if (load) begin
                cnt      <= 6'd0;
                partial  <= {33'd0, absA};
                divisor  <= absB;
                signedOp <= signed_div_i;
                signA    <= opdata1_i[31];
                signB    <= opdata2_i[31];
            end else if (step) begin
                cnt     <= cnt + 6'd1;
                partial <= stepVal;
            end

            if (finish) begin
                result_o <= {rem, quot};
                ready_o  <= 1'b1;
            end else if (dzDone) begin
                result_o <= 64'h0;
                ready_o  <= 1'b1;
            end else if (clear) begin
                result_o <= 64'h0;
                ready_o  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/iter_div.md
ITER_DIV -- requirements
Module: iter_div

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately, independent of clk.
REQ-003 start_i  input  1  division request; held high by initiator until ready_o seen.
REQ-004 annul_i  input  1  cancel; aborts any in-flight or pending operation.
REQ-005 signed_div_i  input  1  1 = two's-complement divide, 0 = unsigned.
REQ-006 opdata1_i  input  32  dividend.
REQ-007 opdata2_i  input  32  divisor.
REQ-008 result_o  output  64  {remainder[63:32], quotient[31:0]}; remainder feeds HI, quotient feeds LO.
REQ-009 ready_o  output  1  result_o valid; registered.

Function
REQ-010 States: IDLE, ON, DZ (present only per REQ-027), END; encoded in a registered state variable.
REQ-011 IDLE: start_i=1 and annul_i=0 at edge E -> latch signed_div_i, |opdata1_i|, |opdata2_i| (abs only when signed), original operand signs; clear 6-bit iteration counter; go ON.
REQ-012 IDLE with annul_i=1: start_i ignored; remain IDLE.
REQ-013 Operands and signed_div_i are sampled only at the start edge; later input changes have no effect on the running operation.
REQ-014 ON: one restoring shift-subtract step per cycle on a 65-bit partial-remainder/quotient register; counter increments each step.
REQ-015 After 32 steps, apply sign correction and go END; ready_o=1 and result_o valid after edge E+33.
REQ-016 Signed correction: quotient negated when operand signs differ; remainder takes the dividend's sign.
REQ-017 Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0 (wraps, no trap).
REQ-018 ON with annul_i=1: next edge -> IDLE, ready_o=0, result_o=0; partial result discarded.
REQ-019 END: ready_o=1, result_o held stable while start_i=1 and annul_i=0.
REQ-020 END with start_i=0 or annul_i=1: next edge -> IDLE, ready_o=0, result_o=0.
REQ-021 Back-to-back: new operation begins only from IDLE; start_i must be observed low (or annul) in END before the next request is accepted.
REQ-022 ready_o never asserted outside END; result_o=0 whenever ready_o=0.

Reset
REQ-023 rst=0: state=IDLE, counter=0, ready_o=0, result_o=64'h0, all operand and sign registers 0.
REQ-024 Reset mid-operation (ON/DZ/END): operation lost; no ready_o pulse after rst release.
REQ-025 After rst release, first request accepted on first rising edge with start_i=1, annul_i=0.

Configuration
REQ-026 Macro ITER_DIV_ZERO_FAST_EN selects divide-by-zero handling.
REQ-027 Defined: IDLE start with opdata2_i=0 -> DZ; next edge -> END with result_o=64'h0; ready_o=1 after edge E+2.
REQ-028 Undefined: DZ state absent; zero divisor runs the normal 32 steps; unsigned result = {opdata1, 32'hFFFFFFFF}, ready_o after edge E+33.

Verification
REQ-029 Unsigned 100/7, start held -> ready_o=1 after edge E+33, result_o={32'd2, 32'd14}; held stable until start_i drops.
REQ-030 Signed -7 (0xFFFFFFF9) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 0x80000000/0xFFFFFFFF -> {0, 0x80000000}.
REQ-031 annul_i pulsed at step 10 of 0xFFFFFFFF/3 -> IDLE next edge, ready_o stays 0; immediate new start 9/3 -> {0, 3} at E+33.
REQ-032 Divisor 0, dividend 0x12345678 unsigned -> macro on: {0,0} at E+2; macro off: {0x12345678, 0xFFFFFFFF} at E+33.
REQ-033 rst asserted asynchronously (between edges) during ON -> ready_o/result_o 0 immediately; after release 50/5 -> {0, 10} at E+33.
REQ-034 Operands changed every cycle during ON for 1000/10 -> result {0, 100} unaffected.
